// File: rtl/result_display.sv
`default_nettype none
// ============================================================================
// Module   : result_display
// Purpose  : Double-dabble BCD conversion of the adder sum, driving a 4-digit
//            common-anode multiplexed seven-segment display.
// Option   : LEADING_ZERO_BLANK_EN blanks leading zero hundreds/tens digits.
// Revision : 1.0 - initial release
// ============================================================================
module result_display #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s,
    input  logic       cout,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       busy
);

    localparam int            RW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [RW-1:0] RCNT_MAX  = RW'(REFRESH_DIV - 1);
    localparam logic [6:0]    SEG_BLANK = 7'b1111111;
    localparam logic [6:0]    SEG_C     = 7'b1000110;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_q,    state_d;
    logic [7:0]    last_val_q, last_val_d;
    logic          last_c_q,   last_c_d;
    logic [19:0]   sh_q,       sh_d;
    logic [2:0]    cnt_q,      cnt_d;
    logic [3:0]    d0_q,       d0_d;
    logic [3:0]    d1_q,       d1_d;
    logic [3:0]    d2_q,       d2_d;
    logic          dc_q,       dc_d;
    logic          busy_q,     busy_d;
    logic [RW-1:0] rcnt_q,     rcnt_d;
    logic [1:0]    sel_q,      sel_d;

    logic [19:0]   sh_adj;
    logic          blank_d1;
    logic          blank_d2;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    assign sh_adj = {add3(sh_q[19:16]), add3(sh_q[15:12]), add3(sh_q[11:8]), sh_q[7:0]};

    always_comb begin
        state_d    = state_q;
        last_val_d = last_val_q;
        last_c_d   = last_c_q;
        sh_d       = sh_q;
        cnt_d      = cnt_q;
        d0_d       = d0_q;
        d1_d       = d1_q;
        d2_d       = d2_q;
        dc_d       = dc_q;

        case (state_q)
            IDLE: begin
                // Any change of sum or carry restarts conversion; no handshake.
                if ((s != last_val_q) || (cout != last_c_q)) begin
                    last_val_d = s;
                    last_c_d   = cout;
                    sh_d       = {12'd0, s};
                    cnt_d      = 3'd0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                sh_d  = {sh_adj[18:0], 1'b0};
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                d2_d    = sh_q[19:16];
                d1_d    = sh_q[15:12];
                d0_d    = sh_q[11:8];
                dc_d    = last_c_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);

        if (rcnt_q == RCNT_MAX) begin
            rcnt_d = '0;
            sel_d  = sel_q + 2'd1;
        end else begin
            rcnt_d = rcnt_q + 1'b1;
            sel_d  = sel_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_val_q <= 8'd0;
            last_c_q   <= 1'b0;
            sh_q       <= 20'd0;
            cnt_q      <= 3'd0;
            d0_q       <= 4'd0;
            d1_q       <= 4'd0;
            d2_q       <= 4'd0;
            dc_q       <= 1'b0;
            busy_q     <= 1'b0;
            rcnt_q     <= '0;
            sel_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            last_val_q <= last_val_d;
            last_c_q   <= last_c_d;
            sh_q       <= sh_d;
            cnt_q      <= cnt_d;
            d0_q       <= d0_d;
            d1_q       <= d1_d;
            d2_q       <= d2_d;
            dc_q       <= dc_d;
            busy_q     <= busy_d;
            rcnt_q     <= rcnt_d;
            sel_q      <= sel_d;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    assign blank_d2 = (d2_q == 4'd0);
    assign blank_d1 = (d2_q == 4'd0) && (d1_q == 4'd0);
`else
    assign blank_d2 = 1'b0;
    assign blank_d1 = 1'b0;
`endif

    always_comb begin
        seg = SEG_BLANK;
        case (sel_q)
            2'd0:    seg = seg7(d0_q);
            2'd1:    seg = blank_d1 ? SEG_BLANK : seg7(d1_q);
            2'd2:    seg = blank_d2 ? SEG_BLANK : seg7(d2_q);
            default: seg = dc_q ? SEG_C : SEG_BLANK;
        endcase
    end

    assign an   = ~(4'b0001 << sel_q);
    assign busy = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_result_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_result_display
// Purpose  : Self-checking bench for result_display (REFRESH_DIV = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_result_display;

    localparam int         REFRESH_DIV = 4;
    localparam logic [6:0] BLANK       = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] s;
    logic       cout;
    logic [6:0] seg;
    logic [3:0] an;
    logic       busy;

    result_display #(.REFRESH_DIV(REFRESH_DIV)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .s    (s),
        .cout (cout),
        .seg  (seg),
        .an   (an),
        .busy (busy)
    );

    always #5 clk = ~clk;

    typedef logic [3:0][6:0] exp_t;
    typedef struct {
        logic [7:0] s;
        logic       c;
        logic [3:0] d2;
        logic [3:0] d1;
        logic [3:0] d0;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t vecs[8];

    function automatic logic [6:0] code7(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return BLANK;
        endcase
    endfunction

    function automatic exp_t make_exp(input logic [3:0] d2, input logic [3:0] d1,
                                      input logic [3:0] d0, input logic c);
        exp_t e;
        e[0] = code7(d0);
        e[1] = code7(d1);
        e[2] = code7(d2);
        e[3] = c ? 7'b1000110 : BLANK;
`ifdef LEADING_ZERO_BLANK_EN
        if (d2 == 4'd0) begin
            e[2] = BLANK;
            if (d1 == 4'd0) e[1] = BLANK;
        end
`endif
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Counts edges from the first edge after the drive until busy drops.
    task automatic run_conv(output int edges, output int first_edge, output bit ok);
        bit seen;
        seen       = 1'b0;
        ok         = 1'b0;
        edges      = 0;
        first_edge = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (busy && !seen) begin
                seen       = 1'b1;
                first_edge = n;
            end else if (!busy && seen) begin
                edges = n;
                ok    = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_slot(input exp_t e, input string tag);
        int idx;
        idx = -1;
        case (an)
            4'b1110: idx = 0;
            4'b1101: idx = 1;
            4'b1011: idx = 2;
            4'b0111: idx = 3;
            default: idx = -1;
        endcase
        if (idx < 0) chk({tag, " anode one-hot"}, an, 4'b1110);
        else chk($sformatf("%s slot%0d seg", tag, idx), seg, e[idx]);
    endtask

    task automatic check_scan(input exp_t e, input string tag);
        for (int k = 0; k < 4; k++) begin
            logic [3:0] want_an;
            bit         found;
            want_an = ~(4'b0001 << k);
            found   = 1'b0;
            for (int t = 0; t < 24; t++) begin
                if (an === want_an) begin
                    found = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            if (!found) fail_timeout($sformatf("%s slot%0d", tag, k));
            else chk($sformatf("%s slot%0d seg", tag, k), seg, e[k]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   edges, first_edge;
        bit   ok, busy_seen;
        exp_t cur;
        logic [3:0] an_cur;
        int   len;

        vecs[0] = '{s: 8'd12,  c: 1'b0, d2: 4'd0, d1: 4'd1, d0: 4'd2};
        vecs[1] = '{s: 8'd255, c: 1'b1, d2: 4'd2, d1: 4'd5, d0: 4'd5};
        vecs[2] = '{s: 8'd0,   c: 1'b1, d2: 4'd0, d1: 4'd0, d0: 4'd0};
        vecs[3] = '{s: 8'd100, c: 1'b0, d2: 4'd1, d1: 4'd0, d0: 4'd0};
        vecs[4] = '{s: 8'd9,   c: 1'b0, d2: 4'd0, d1: 4'd0, d0: 4'd9};
        vecs[5] = '{s: 8'd200, c: 1'b1, d2: 4'd2, d1: 4'd0, d0: 4'd0};
        vecs[6] = '{s: 8'd47,  c: 1'b0, d2: 4'd0, d1: 4'd4, d0: 4'd7};
        vecs[7] = '{s: 8'd199, c: 1'b0, d2: 4'd1, d1: 4'd9, d0: 4'd9};

        // Reset state and idle behaviour with zero inputs.
        rst_n = 1'b0;
        s     = 8'd0;
        cout  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset busy", busy, 1'b0);
        chk("reset an", an, 4'b1110);
        chk("reset seg", seg, 7'b1000000);
        rst_n     = 1'b1;
        busy_seen = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            busy_seen |= busy;
            if (i == 3) chk("an before first slot change", an, 4'b1110);
            if (i == 4) chk("an after REFRESH_DIV cycles", an, 4'b1101);
        end
        chk("idle busy never set", busy_seen, 1'b0);

        // Anode dwell and rotation order.
        an_cur = an;
        for (int t = 0; t < 8 && an === an_cur; t++) @(negedge clk);
        for (int r = 0; r < 5; r++) begin
            an_cur = an;
            len    = 0;
            for (int t = 0; t < 10 && an === an_cur; t++) begin
                len++;
                @(negedge clk);
            end
            chk($sformatf("dwell run%0d", r), len, REFRESH_DIV);
            chk($sformatf("rotation run%0d", r), an, {an_cur[2:0], an_cur[3]});
        end

        // Table of conversions, checked through the scoreboard.
        foreach (vecs[i]) begin
            @(negedge clk);
            s    = vecs[i].s;
            cout = vecs[i].c;
            sb.push_back(make_exp(vecs[i].d2, vecs[i].d1, vecs[i].d0, vecs[i].c));
            run_conv(edges, first_edge, ok);
            if (!ok) fail_timeout($sformatf("vec%0d conversion", i));
            else begin
                chk($sformatf("vec%0d busy rise edge", i), first_edge, 1);
                chk($sformatf("vec%0d busy fall edge", i), edges, 10);
            end
            if (sb.size() > 0) begin
                cur = sb.pop_front();
                check_scan(cur, $sformatf("vec%0d", i));
            end
        end

        // Input change mid-conversion is picked up on the next idle cycle.
        @(negedge clk);
        s    = 8'd30;
        cout = 1'b0;
        sb.push_back(make_exp(4'd0, 4'd3, 4'd0, 1'b0));
        cur = '0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 3) begin
                s = 8'd7;
                sb.push_back(make_exp(4'd0, 4'd0, 4'd7, 1'b0));
            end
            if (n == 10) begin
                chk("b2b first done busy", busy, 1'b0);
                if (sb.size() > 0) cur = sb.pop_front();
            end
            if (n >= 10 && n <= 19) check_slot(cur, $sformatf("b2b 030 n%0d", n));
            if (n == 11) chk("b2b restart busy", busy, 1'b1);
            if (n == 19) chk("b2b second busy", busy, 1'b1);
            if (n == 20) chk("b2b second done busy", busy, 1'b0);
        end
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            check_scan(cur, "b2b 007");
        end

        // Reset in the middle of a conversion of 99.
        @(negedge clk);
        s    = 8'd99;
        cout = 1'b1;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("mid-conv busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("abort busy", busy, 1'b0);
        chk("abort an", an, 4'b1110);
        chk("abort seg", seg, 7'b1000000);
        @(negedge clk);
        cout  = 1'b0;
        rst_n = 1'b1;
        sb.push_back(make_exp(4'd0, 4'd9, 4'd9, 1'b0));
        run_conv(edges, first_edge, ok);
        if (!ok) fail_timeout("post-reset conversion");
        else begin
            chk("post-reset busy rise edge", first_edge, 1);
            chk("post-reset busy fall edge", edges, 10);
        end
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            check_scan(cur, "post-reset 099");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
